// File: rtl/clk_meas.sv
// Measures the period and high time of a slow asynchronous signal in clk_in cycles.
// Reports each complete rising-edge-to-rising-edge cycle; flags a sticky timeout when edges stop.
module clk_meas #(
    parameter int unsigned wide    = 24,
    parameter int unsigned max_cnt = 6_000_000
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            en,
    input  logic            sig_in,
    output logic [wide-1:0] period,
    output logic [wide-1:0] high_time,
    output logic            valid,
    output logic            timeout,
    output logic            busy
);

    localparam logic [wide-1:0] cnt_max = wide'(max_cnt);
    localparam logic [wide-1:0] cnt_one = wide'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            sync_1;
    logic            sync_2;
    logic            sync_3;
    logic            rise_c;
    logic            at_max_c;

    logic [wide-1:0] per_cnt;
    logic [wide-1:0] hi_cnt;
    logic [wide-1:0] per_cnt_nxt;
    logic [wide-1:0] hi_cnt_nxt;
    logic [wide-1:0] period_nxt;
    logic [wide-1:0] high_time_nxt;
    logic            valid_nxt;
    logic            timeout_nxt;
    logic            busy_nxt;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= sig_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign rise_c   = sync_2 & ~sync_3;
    assign at_max_c = (per_cnt == cnt_max);

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping en always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise_c) state_nxt = MEAS;
                MEAS:    if (!rise_c && at_max_c) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counter and result update; a rise coinciding with the limit still reports.
    always_comb begin
        per_cnt_nxt   = per_cnt;
        hi_cnt_nxt    = hi_cnt;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;
        busy_nxt      = (state_nxt != IDLE);
        if (!en) begin
            per_cnt_nxt = '0;
            hi_cnt_nxt  = '0;
            timeout_nxt = 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (rise_c) begin
                        per_cnt_nxt = cnt_one;
                        hi_cnt_nxt  = cnt_one;
                    end else begin
                        per_cnt_nxt = '0;
                        hi_cnt_nxt  = '0;
                    end
                end
                MEAS: begin
                    if (rise_c) begin
                        period_nxt    = per_cnt;
                        high_time_nxt = hi_cnt;
                        valid_nxt     = 1'b1;
                        timeout_nxt   = 1'b0;
                        per_cnt_nxt   = cnt_one;
                        hi_cnt_nxt    = cnt_one;
                    end else if (at_max_c) begin
                        timeout_nxt = 1'b1;
                        per_cnt_nxt = '0;
                        hi_cnt_nxt  = '0;
                    end else begin
                        per_cnt_nxt = per_cnt + cnt_one;
                        hi_cnt_nxt  = hi_cnt + wide'(sync_2);
                    end
                end
                default: begin
                    per_cnt_nxt = '0;
                    hi_cnt_nxt  = '0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            per_cnt   <= per_cnt_nxt;
            hi_cnt    <= hi_cnt_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
